// File: rtl/sec_pkg.sv
// Shared definitions for the clock/calendar chain: seconds-stage constants
// and the edit-item select encoding used by every stage.
package sec_pkg;

    localparam int SEC_W   = 6;
    localparam int SEC_MAX = 59;

    // Which stage the up/down edit controls currently act on.
    typedef enum logic [2:0] {
        SEL_SEC  = 3'b000,
        SEL_MIN  = 3'b001,
        SEL_HOUR = 3'b010,
        SEL_DATE = 3'b011,
        SEL_NONE = 3'b111
    } sel_item_e;

endpackage : sec_pkg

// File: rtl/mod_n_updown.sv
// Generic wrap-around up/down counter over 0..MAX with synchronous clear.
// Out-of-range values recover on the next step: an increment loads 0 and a
// decrement loads MAX. The terminal flag is exact, so an out-of-range value
// never reports terminal.
module mod_n_updown #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         terminal
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = W'(1);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Next-count: step up or down with wrap; simultaneous requests hold.
    always_comb begin
        // NOTE: the default assignment first means every path drives count_d, so no latch is inferred.
        count_d = count_q;
        if (inc && !dec) begin
            count_d = (count_q >= MAX_V) ? '0 : count_q + ONE_V;
        end else if (dec && !inc) begin
            count_d = ((count_q == '0) || (count_q > MAX_V)) ? MAX_V : count_q - ONE_V;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment keeps every flop sampling pre-edge values, avoiding simulation races.
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign terminal = (count_q == MAX_V);

endmodule : mod_n_updown

// File: rtl/sec_counter.sv
// Seconds stage of the clock/calendar chain. Counts 0..MAX_VAL on enabled
// 1 Hz ticks in run mode, steps with up/down in seconds-edit mode, and
// strobes carry_out for the minute stage on the run-mode 59->0 rollover.
// Build option: define SEC_EDIT_EDGE_EN to make up/down step once per press
// (rising edge) instead of once per cycle held.
module sec_counter
    import sec_pkg::*;
#(
    parameter int MAX_VAL = SEC_MAX,
    parameter int CNT_W   = SEC_W
) (
    input  logic             clk_1Hz,
    input  logic             rst,
    input  logic             en_1,
    input  logic             up,
    input  logic             down,
    input  logic [2:0]       select_item,
    output logic [CNT_W-1:0] sec_bin,
    output logic             carry_out
);

    logic edit;
    logic run;
    logic up_step;
    logic down_step;
    logic cnt_inc;
    logic cnt_dec;
    logic at_max;

    assign edit = (select_item == SEL_SEC);
    assign run  = !edit;

`ifdef SEC_EDIT_EDGE_EN
    logic up_d;
    logic up_q;
    logic down_d;
    logic down_q;

    // Previous-cycle copies of the edit requests for rising-edge detection.
    always_comb begin
        up_d   = up;
        down_d = down;
    end

    // Edge-detect registers, cleared by reset so a held button after reset counts as a fresh press.
    always_ff @(posedge clk_1Hz) begin
        if (rst) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
        end else begin
            up_q   <= up_d;
            down_q <= down_d;
        end
    end

    assign up_step   = up && !up_q;
    assign down_step = down && !down_q;
`else
    assign up_step   = up;
    assign down_step = down;
`endif

    // Step requests: ticks drive the counter in run mode, edit controls in edit mode.
    always_comb begin
        cnt_inc = 1'b0;
        cnt_dec = 1'b0;
        if (run) begin
            cnt_inc = en_1;
        end else if (up_step && !down_step) begin
            cnt_inc = 1'b1;
        end else if (down_step && !up_step) begin
            cnt_dec = 1'b1;
        end
    end

    mod_n_updown #(
        .W   (CNT_W),
        .MAX (MAX_VAL)
    ) u_count (
        .clk      (clk_1Hz),
        .clear    (rst),
        .inc      (cnt_inc),
        .dec      (cnt_dec),
        .count    (sec_bin),
        .terminal (at_max)
    );

    // High during the cycle whose edge performs the run-mode rollover.
    assign carry_out = !rst && run && en_1 && at_max;

endmodule : sec_counter

// File: tb/tb_sec_counter.sv
// Directed self-checking bench for sec_counter.
module tb_sec_counter;

    logic       clk_1Hz;
    logic       rst;
    logic       en_1;
    logic       up;
    logic       down;
    logic [2:0] select_item;
    logic [5:0] sec_bin;
    logic       carry_out;

    int tests_run = 0;
    int tests_failed = 0;

    sec_counter dut (
        .clk_1Hz     (clk_1Hz),
        .rst         (rst),
        .en_1        (en_1),
        .up          (up),
        .down        (down),
        .select_item (select_item),
        .sec_bin     (sec_bin),
        .carry_out   (carry_out)
    );

    initial clk_1Hz = 1'b0;
    always #5 clk_1Hz = ~clk_1Hz;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en_1 = 1'b0; up = 1'b0; down = 1'b0; select_item = 3'b111;
        tick();
        tick();
        tests_run++;
        if (sec_bin !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_value: got %0d expected 0", sec_bin);
        end
        tests_run++;
        if (carry_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_carry: got %b expected 0", carry_out);
        end
        // Count up to 37, then reset from there.
        rst = 1'b0; en_1 = 1'b1;
        for (int i = 0; i < 37; i++) tick();
        tests_run++;
        if (sec_bin !== 6'd37) begin
            tests_failed++;
            $display("FAIL count_to_37: got %0d expected 37", sec_bin);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (sec_bin !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_from_37: got %0d expected 0", sec_bin);
        end
        en_1 = 1'b0;
        tick();
    endtask

    task automatic test_auto_count();
        logic [5:0] exp_sec;
        int carries;
        exp_sec = 6'd0;
        carries = 0;
        rst = 1'b0; en_1 = 1'b1; select_item = 3'b111;
        #1;
        for (int i = 0; i < 65; i++) begin
            tests_run++;
            if (carry_out !== (exp_sec == 6'd59)) begin
                tests_failed++;
                $display("FAIL auto_carry[%0d]: got %b at sec %0d", i, carry_out, exp_sec);
            end
            if (carry_out === 1'b1) carries++;
            tick();
            exp_sec = (exp_sec == 6'd59) ? 6'd0 : exp_sec + 6'd1;
            tests_run++;
            if (sec_bin !== exp_sec) begin
                tests_failed++;
                $display("FAIL auto_value[%0d]: got %0d expected %0d", i, sec_bin, exp_sec);
            end
        end
        tests_run++;
        if (sec_bin !== 6'd5) begin
            tests_failed++;
            $display("FAIL auto_final: got %0d expected 5", sec_bin);
        end
        tests_run++;
        if (carries != 1) begin
            tests_failed++;
            $display("FAIL auto_carry_count: got %0d expected 1", carries);
        end
    endtask

    task automatic test_edit_steps();
        logic [5:0] exp_tab [3];
        logic       is_up [3];
        exp_tab[0] = 6'd6; exp_tab[1] = 6'd7; exp_tab[2] = 6'd6;
        is_up[0] = 1'b1; is_up[1] = 1'b1; is_up[2] = 1'b0;
        select_item = 3'b000; en_1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            up = is_up[i]; down = !is_up[i];
            #1;
            tests_run++;
            if (carry_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL edit_carry[%0d]: got %b expected 0", i, carry_out);
            end
            tick();
            up = 1'b0; down = 1'b0;
            tick();
            tests_run++;
            if (sec_bin !== exp_tab[i]) begin
                tests_failed++;
                $display("FAIL edit_step[%0d]: got %0d expected %0d", i, sec_bin, exp_tab[i]);
            end
        end
        en_1 = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if (sec_bin !== 6'd6) begin
            tests_failed++;
            $display("FAIL edit_ignores_en: got %0d expected 6", sec_bin);
        end
        en_1 = 1'b0;
    endtask

`ifndef SEC_EDIT_EDGE_EN
    task automatic test_edit_wrap();
        logic [5:0] exp_sec;
        exp_sec = 6'd6;
        select_item = 3'b000; en_1 = 1'b1; up = 1'b1; down = 1'b0;
        for (int i = 0; i < 60; i++) begin
            #1;
            tests_run++;
            if (carry_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL wrap_carry[%0d]: got %b at sec %0d", i, carry_out, sec_bin);
            end
            tick();
            exp_sec = (exp_sec == 6'd59) ? 6'd0 : exp_sec + 6'd1;
            tests_run++;
            if (sec_bin !== exp_sec) begin
                tests_failed++;
                $display("FAIL wrap_value[%0d]: got %0d expected %0d", i, sec_bin, exp_sec);
            end
        end
        tests_run++;
        if (sec_bin !== 6'd6) begin
            tests_failed++;
            $display("FAIL wrap_final: got %0d expected 6", sec_bin);
        end
        // 54 more steps bring 6 to 0.
        for (int i = 0; i < 54; i++) tick();
        tests_run++;
        if (sec_bin !== 6'd0) begin
            tests_failed++;
            $display("FAIL wrap_to_zero: got %0d expected 0", sec_bin);
        end
        up = 1'b0; down = 1'b1;
        tick();
        tests_run++;
        if (sec_bin !== 6'd59) begin
            tests_failed++;
            $display("FAIL down_wrap: got %0d expected 59", sec_bin);
        end
        tests_run++;
        if (carry_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL down_wrap_carry: got %b expected 0", carry_out);
        end
        // Seven up steps: 59 -> 0 -> ... -> 6.
        up = 1'b1; down = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        up = 1'b0; en_1 = 1'b0;
        tests_run++;
        if (sec_bin !== 6'd6) begin
            tests_failed++;
            $display("FAIL wrap_restore: got %0d expected 6", sec_bin);
        end
    endtask
`endif

    task automatic test_resume();
        logic [5:0] exp_tab [3];
        exp_tab[0] = 6'd7; exp_tab[1] = 6'd8; exp_tab[2] = 6'd9;
        select_item = 3'b111; en_1 = 1'b1; up = 1'b0; down = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (sec_bin !== exp_tab[i]) begin
                tests_failed++;
                $display("FAIL resume[%0d]: got %0d expected %0d", i, sec_bin, exp_tab[i]);
            end
        end
        // down is ignored while running.
        down = 1'b1;
        tick();
        down = 1'b0;
        tests_run++;
        if (sec_bin !== 6'd10) begin
            tests_failed++;
            $display("FAIL run_ignores_down: got %0d expected 10", sec_bin);
        end
    endtask

    task automatic test_hold();
        select_item = 3'b000; en_1 = 1'b0; up = 1'b1; down = 1'b1;
        tick();
        up = 1'b0; down = 1'b0;
        tick();
        tests_run++;
        if (sec_bin !== 6'd10) begin
            tests_failed++;
            $display("FAIL edit_both_hold: got %0d expected 10", sec_bin);
        end
        select_item = 3'b111; en_1 = 1'b0; up = 1'b1;
        tick();
        tick();
        up = 1'b0;
        tests_run++;
        if (sec_bin !== 6'd10) begin
            tests_failed++;
            $display("FAIL run_up_hold: got %0d expected 10", sec_bin);
        end
        tick();
    endtask

`ifdef SEC_EDIT_EDGE_EN
    task automatic test_edge_detect();
        select_item = 3'b000; en_1 = 1'b0; up = 1'b1; down = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        up = 1'b0;
        tick();
        tests_run++;
        if (sec_bin !== 6'd11) begin
            tests_failed++;
            $display("FAIL edge_held: got %0d expected 11", sec_bin);
        end
        for (int i = 0; i < 2; i++) begin
            up = 1'b1;
            tick();
            up = 1'b0;
            tick();
        end
        tests_run++;
        if (sec_bin !== 6'd13) begin
            tests_failed++;
            $display("FAIL edge_pulses: got %0d expected 13", sec_bin);
        end
    endtask
`endif

    task automatic test_reset_priority();
        select_item = 3'b111; en_1 = 1'b1; up = 1'b0; down = 1'b0;
        for (int i = 0; i < 64 && sec_bin !== 6'd59; i++) tick();
        tests_run++;
        if (sec_bin !== 6'd59) begin
            tests_failed++;
            $display("FAIL reach_59: got %0d expected 59", sec_bin);
        end
        tests_run++;
        if (carry_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL carry_at_59: got %b expected 1", carry_out);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (carry_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL carry_under_rst: got %b expected 0", carry_out);
        end
        tick();
        rst = 1'b0; en_1 = 1'b0;
        tests_run++;
        if (sec_bin !== 6'd0) begin
            tests_failed++;
            $display("FAIL rst_priority: got %0d expected 0", sec_bin);
        end
    endtask

    initial begin
        test_reset();
        test_auto_count();
        test_edit_steps();
`ifndef SEC_EDIT_EDGE_EN
        test_edit_wrap();
`endif
        test_resume();
        test_hold();
`ifdef SEC_EDIT_EDGE_EN
        test_edge_detect();
`endif
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_sec_counter

// File: doc/sec_counter.md
Name: sec_counter

Overview:
- Seconds stage of the clock/calendar chain; holds seconds as 6-bit binary, 0..59.
- Auto-increments once per enabled 1 Hz tick.
- Emits a carry strobe that drives the minute stage on the 59->0 rollover.
- In seconds-edit mode (select_item = 3'b000), the value is stepped by the up/down controls instead of counting.

Parameters:
- MAX_VAL, 59, highest count value; wraps to 0 above it.
- CNT_W, 6, width of sec_bin; must satisfy 2**CNT_W > MAX_VAL.

Ports:
- clk_1Hz  input  1  counting clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en_1  input  1  one-second tick enable for auto counting.
- up  input  1  edit increment request, active-high.
- down  input  1  edit decrement request, active-high.
- select_item  input  3  edit item select; 3'b000 = seconds edit mode, any other value = not editing seconds.
- sec_bin  output  CNT_W  current seconds, binary 0..MAX_VAL.
- carry_out  output  1  rollover strobe to the minute stage.

Behaviour:
- Reset: when rst=1 at a rising edge, sec_bin <= 0; this has priority over all other inputs. carry_out is 0 while rst=1.
- Mode select: edit = (select_item == 3'b000); run = !edit.
- Run mode, en_1=1:
  - sec_bin <= (sec_bin == MAX_VAL) ? 0 : sec_bin + 1.
  - up and down are ignored.
- Run mode, en_1=0: hold.
- Edit mode: en_1 is ignored; auto counting is suspended.
  - up=1, down=0: increment with wrap, MAX_VAL -> 0.
  - down=1, up=0: decrement with wrap, 0 -> MAX_VAL.
  - up=1, down=1: hold.
  - Neither asserted: hold.
- Step size: each rising edge with a request asserted steps exactly 1. Requests are level-sensitive in the default build, so a request held N cycles steps N.
- carry_out: combinational.
  - carry_out = !rst && run && en_1 && (sec_bin == MAX_VAL).
  - It is high during the cycle whose rising edge performs 59->0, so the minute stage advances on the same edge.
  - Edit-mode wraps never assert carry_out.
- Out-of-range state (sec_bin > MAX_VAL, unreachable): the next increment or tick loads 0, the next decrement loads MAX_VAL, and carry_out stays 0.
- Latency: sec_bin updates one edge after inputs are sampled; there are no other pipeline stages.
- Reset mid-edit: value returns to 0; mode is re-evaluated from select_item on the next edge.

Optional Feature:
- Macro SEC_EDIT_EDGE_EN.
- Defined:
  - up and down are registered, and only a 0->1 transition produces a step, i.e. one step per press regardless of hold length.
  - The edge-detect registers clear on rst.
  - Simultaneous rising edges of up and down mean hold.
- Undefined: level-sensitive stepping as described above.
- All other behaviour is identical in both builds.

Decomposition:
- Package sec_pkg holds:
  - SEC_W = 6
  - SEC_MAX = 59
  - SEL_SEC = 3'b000
  - the select_item encoding type shared with the minute/hour/date stages.
- One natural sub-module is mod_n_updown, a generic wrap-around up/down counter (inc, dec, load-zero, terminal flag).
- The sec_counter top adds the mode decode, the carry logic and the optional edge detect.

Test Plan:
- Reset: hold rst=1 for 2 edges with en_1=0 -> sec_bin=0, carry_out=0. Assert rst with sec_bin=37 -> 0 on the next edge.
- Auto count: release rst, en_1=1, select_item=3'b111, run 65 edges -> sec_bin=5.
  - carry_out is high only during the single cycle where sec_bin=59.
  - After that edge, sec_bin=0.
- Edit steps: from sec_bin=5, select_item=3'b000, en_1=0. Apply up, up, down for one cycle each -> 6, 7, 6.
  - Then en_1=1 with no up/down -> value holds at 6.
- Edit wrap: from 6, up held 60 consecutive edges -> sec_bin=6, passing 59->0 with carry_out=0 throughout.
  - From 0, one down -> 59, carry_out=0.
- Resume: select_item=3'b111, en_1=1, 3 edges -> sec_bin 7, 8, 9.
  - up=down=1 in edit mode -> hold.
  - up asserted in run mode with en_1=0 -> hold.
- Optional SEC_EDIT_EDGE_EN build: up held high 5 cycles in edit mode -> exactly +1. Two separate 1-cycle pulses separated by a low cycle -> +2.
